// File: rtl/rv_mem_sequencer_if.sv
// Shared memory channel between rv_mem_sequencer (master) and the memory (slave).
// A transfer completes in the cycle where mem_req && mem_ack.
interface rv_mem_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [60:0] mem_address;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_funct3, mem_address, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_funct3, mem_address, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/rv_mem_sequencer.sv
// Multi-cycle sequencer for one rv_cpu: owns pc, fetches the instruction window and
// serialises fetch and data accesses onto one memory port. RV_MEM_SEQUENCER_FETCH_CACHE_EN adds a 2-entry fetch buffer.
module rv_mem_sequencer #(
  parameter logic [63:0] reset_pc = 64'h0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [62:0]          cpu_pc,
  output logic [63:0]          cpu_inst,
  input  logic [62:0]          cpu_pcnext,
  input  logic                 cpu_halt,
  input  logic                 cpu_ram_load,
  input  logic                 cpu_ram_store,
  input  logic [2:0]           cpu_ram_funct3,
  input  logic [60:0]          cpu_ram_address,
  input  logic [63:0]          cpu_ram_store_value,
  output logic [63:0]          cpu_ram_load_value,
  output logic                 commit,
  output logic                 halted,
  rv_mem_sequencer_if.master   mem
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH0 = 3'd1;
  localparam logic [2:0] FETCH1 = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;
  localparam logic [2:0] HALTED = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [62:0] pc_q, pc_d;
  logic [62:0] pcnext_q;
  logic [60:0] addr_q;
  logic [2:0]  funct3_q;
  logic [63:0] wdata_q;
  logic        we_q;
  logic [63:0] fetch_lo_q;
  logic [63:0] inst_q;
  logic [63:0] load_q;

  logic        in_fetch;
  logic [60:0] fetch_addr;
  logic        fetch_hit;
  logic [63:0] hit_data;
  logic        xfer;
  logic        fetch_done;
  logic [63:0] fetch_word;
  logic [63:0] fetch_window;
  logic        misaligned;
  logic        exec_commit;

  assign in_fetch   = (state_q == FETCH0) || (state_q == FETCH1);
  assign fetch_addr = (state_q == FETCH1) ? pc_q[62:2] + 61'd1 : pc_q[62:2];
  assign misaligned = pc_q[1:0] != 2'b00;

  assign mem.mem_req = (in_fetch && !fetch_hit) || (state_q == DATA);
  assign xfer        = mem.mem_req && mem.mem_ack;
  assign fetch_done  = in_fetch && (fetch_hit || xfer);
  assign fetch_word  = fetch_hit ? hit_data : mem.mem_rdata;

  // In FETCH1 fetch_word is the upper doubleword; pc[2:1] selects the 16-bit parcel offset.
  assign fetch_window = 64'({fetch_word, fetch_lo_q} >> {pc_q[1:0], 4'b0000});

  // Fields are driven purely from state and captured registers, so they stay stable until ack.
  assign mem.mem_address = in_fetch ? fetch_addr : (state_q == DATA) ? addr_q : 61'd0;
  assign mem.mem_we      = (state_q == DATA) && we_q;
  assign mem.mem_wdata   = ((state_q == DATA) && we_q) ? wdata_q : 64'd0;
  assign mem.mem_funct3  = in_fetch ? 3'b011 : (state_q == DATA) ? funct3_q : 3'b000;

  assign exec_commit = (state_q == EXEC) && !cpu_halt && !cpu_ram_load && !cpu_ram_store;
  assign commit      = exec_commit || (state_q == COMMIT);
  assign halted      = state_q == HALTED;

  assign cpu_pc             = pc_q;
  assign cpu_inst           = inst_q;
  assign cpu_ram_load_value = load_q;

`ifdef RV_MEM_SEQUENCER_FETCH_CACHE_EN
  logic [60:0] tag_q   [2];
  logic [63:0] cdata_q [2];
  logic [1:0]  valid_q;
  logic        rr_q;
  logic        hit0, hit1;
  logic        fill;
  logic        store_done;

  assign hit0       = valid_q[0] && (tag_q[0] == fetch_addr);
  assign hit1       = valid_q[1] && (tag_q[1] == fetch_addr);
  assign fetch_hit  = in_fetch && (hit0 || hit1);
  assign hit_data   = hit0 ? cdata_q[0] : cdata_q[1];
  assign fill       = in_fetch && xfer;
  assign store_done = (state_q == DATA) && xfer && we_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 2'b00;
      rr_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (store_done && valid_q[i] && (tag_q[i] == addr_q)) valid_q[i] <= 1'b0;
      end
      if (fill) begin
        valid_q[rr_q] <= 1'b1;
        rr_q          <= ~rr_q;
      end
    end
  end

  // NOTE: tag/data storage is not reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[rr_q]   <= fetch_addr;
      cdata_q[rr_q] <= mem.mem_rdata;
    end
  end
`else
  assign fetch_hit = 1'b0;
  assign hit_data  = 64'd0;
`endif

  // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE:   state_d = FETCH0;
      FETCH0: if (fetch_done) state_d = misaligned ? FETCH1 : EXEC;
      FETCH1: if (fetch_done) state_d = EXEC;
      EXEC: begin
        if (cpu_halt)                          state_d = HALTED;
        else if (cpu_ram_load || cpu_ram_store) state_d = DATA;
        else begin
          state_d = FETCH0;
          pc_d    = cpu_pcnext;
        end
      end
      DATA:   if (xfer) state_d = COMMIT;
      COMMIT: begin
        state_d = FETCH0;
        pc_d    = pcnext_q;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= reset_pc[63:1];
      pcnext_q   <= '0;
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      fetch_lo_q <= '0;
      inst_q     <= '0;
      load_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if ((state_q == FETCH0) && fetch_done) begin
        fetch_lo_q <= fetch_word;
        if (!misaligned) inst_q <= fetch_word;
      end
      if ((state_q == FETCH1) && fetch_done) inst_q <= fetch_window;
      // CPU outputs are only valid in EXEC, so everything the access and commit need is held here.
      if (state_q == EXEC) begin
        pcnext_q <= cpu_pcnext;
        addr_q   <= cpu_ram_address;
        funct3_q <= cpu_ram_funct3;
        wdata_q  <= cpu_ram_store_value;
        we_q     <= cpu_ram_store;
      end
      if ((state_q == DATA) && xfer && !we_q) load_q <= mem.mem_rdata;
    end
  end

endmodule

// File: tb/tb_rv_mem_sequencer.sv
// Scoreboard bench for rv_mem_sequencer: directed stimulus pushes expected memory
// transfers and commits into a queue; a monitor pops and compares them as they occur.
module tb_rv_mem_sequencer;

`ifdef RV_MEM_SEQUENCER_FETCH_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [63:0] M200 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] M201 = 64'h8888_7777_6666_5555;
  localparam logic [63:0] M300 = 64'hDEAD_BEEF_CAFE_F00D;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [62:0] cpu_pc;
  logic [63:0] cpu_inst;
  logic [62:0] cpu_pcnext = '0;
  logic        cpu_halt = 1'b0;
  logic        cpu_ram_load = 1'b0;
  logic        cpu_ram_store = 1'b0;
  logic [2:0]  cpu_ram_funct3 = '0;
  logic [60:0] cpu_ram_address = '0;
  logic [63:0] cpu_ram_store_value = '0;
  logic [63:0] cpu_ram_load_value;
  logic        commit;
  logic        halted;

  rv_mem_sequencer_if mem_if ();

  rv_mem_sequencer #(.reset_pc(64'h1000)) dut (
    .clock               (clock),
    .reset               (reset),
    .cpu_pc              (cpu_pc),
    .cpu_inst            (cpu_inst),
    .cpu_pcnext          (cpu_pcnext),
    .cpu_halt            (cpu_halt),
    .cpu_ram_load        (cpu_ram_load),
    .cpu_ram_store       (cpu_ram_store),
    .cpu_ram_funct3      (cpu_ram_funct3),
    .cpu_ram_address     (cpu_ram_address),
    .cpu_ram_store_value (cpu_ram_store_value),
    .cpu_ram_load_value  (cpu_ram_load_value),
    .commit              (commit),
    .halted              (halted),
    .mem                 (mem_if)
  );

  always #5 clock = ~clock;

  typedef enum logic {EV_MEM, EV_COMMIT} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [60:0] addr;
    logic        we;
    logic [2:0]  f3;
    logic [63:0] wdata;
    logic [62:0] pc;
    logic [63:0] inst;
    logic [63:0] ldval;
    int          dly;
  } ev_t;

  ev_t   exp_q[$];
  int    checks = 0;
  int    passes = 0;
  string cur_test = "init";

  logic [63:0] mem_arr [logic [60:0]];
  int          ack_delay = 0;
  logic        stray_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s/%s: got %h required %h", cur_test, name, act, exp);
  endtask

  task automatic push_mem(input logic [60:0] addr, input logic we, input logic [2:0] f3,
                          input logic [63:0] wdata, input logic [62:0] pc, input int dly);
    ev_t e;
    e.kind = EV_MEM; e.addr = addr; e.we = we; e.f3 = f3; e.wdata = wdata;
    e.pc = pc; e.inst = '0; e.ldval = '0; e.dly = dly;
    exp_q.push_back(e);
  endtask

  task automatic push_fetch(input logic [60:0] addr, input logic [62:0] pc, input int dly);
    push_mem(addr, 1'b0, 3'b011, 64'd0, pc, dly);
  endtask

  task automatic push_commit(input logic [62:0] pc, input logic [63:0] inst,
                             input logic [63:0] ldval, input int dly);
    ev_t e;
    e.kind = EV_COMMIT; e.addr = '0; e.we = 1'b0; e.f3 = '0; e.wdata = '0;
    e.pc = pc; e.inst = inst; e.ldval = ldval; e.dly = dly;
    exp_q.push_back(e);
  endtask

  task automatic set_cpu(input logic halt, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [60:0] addr, input logic [63:0] sv, input logic [62:0] pcn);
    cpu_halt = halt; cpu_ram_load = ld; cpu_ram_store = st; cpu_ram_funct3 = f3;
    cpu_ram_address = addr; cpu_ram_store_value = sv; cpu_pcnext = pcn;
  endtask

  task automatic init_mem();
    mem_arr.delete();
    mem_arr[61'h200] = M200;
    mem_arr[61'h201] = M201;
    mem_arr[61'h300] = M300;
  endtask

  // Callers sit at negedge+3, so these edges land well clear of the posedge.
  task automatic enter_reset();
    reset = 1'b0;
    @(negedge clock); #3;
  endtask

  task automatic release_reset();
    @(negedge clock); #3;
    reset = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clock); #3;
    end
    checks++;
    $display("FAIL %s/drain: remaining events %0d required 0", cur_test, exp_q.size());
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", {63'd0, mem_if.mem_req}, 64'd0);
    check("rst_mem_we", {63'd0, mem_if.mem_we}, 64'd0);
    check("rst_mem_address", {3'd0, mem_if.mem_address}, 64'd0);
    check("rst_mem_wdata", mem_if.mem_wdata, 64'd0);
    check("rst_mem_funct3", {61'd0, mem_if.mem_funct3}, 64'd0);
    check("rst_commit", {63'd0, commit}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_cpu_pc", {1'b0, cpu_pc}, 64'h800);
    check("rst_cpu_inst", cpu_inst, 64'd0);
    check("rst_load_value", cpu_ram_load_value, 64'd0);
  endtask

  // Memory responder: decides ack/rdata at each negedge for the coming posedge.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_if.mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = mem_arr.exists(mem_if.mem_address) ? mem_arr[mem_if.mem_address] : 64'd0;
          if (mem_if.mem_we) mem_arr[mem_if.mem_address] = mem_if.mem_wdata;
          wait_cnt = 0;
        end else begin
          mem_if.mem_ack   = 1'b0;
          mem_if.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
          wait_cnt++;
        end
      end else begin
        mem_if.mem_ack   = stray_ack;
        mem_if.mem_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every completed transfer or commit pulse.
  initial begin
    ev_t         e;
    int          cycle;
    int          last_cycle;
    logic        pend;
    logic        is_mem;
    logic [60:0] p_addr;
    logic        p_we;
    logic [2:0]  p_f3;
    logic [63:0] p_wdata;
    cycle = 0; last_cycle = 0; pend = 1'b0;
    p_addr = '0; p_we = 1'b0; p_f3 = '0; p_wdata = '0;
    forever begin
      @(negedge clock); #2;
      cycle++;
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("hold_req", {63'd0, mem_if.mem_req}, 64'd1);
          check("hold_addr", {3'd0, mem_if.mem_address}, {3'd0, p_addr});
          check("hold_we", {63'd0, mem_if.mem_we}, {63'd0, p_we});
          check("hold_funct3", {61'd0, mem_if.mem_funct3}, {61'd0, p_f3});
          check("hold_wdata", mem_if.mem_wdata, p_wdata);
        end
        pend    = mem_if.mem_req && !mem_if.mem_ack;
        p_addr  = mem_if.mem_address;
        p_we    = mem_if.mem_we;
        p_f3    = mem_if.mem_funct3;
        p_wdata = mem_if.mem_wdata;
        is_mem  = mem_if.mem_req && mem_if.mem_ack;
        if (is_mem || commit) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL %s/unexpected_event: got req_ack=%0b commit=%0b addr=%h required no event",
                     cur_test, is_mem, commit, mem_if.mem_address);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", {63'd0, !is_mem}, {63'd0, e.kind == EV_COMMIT});
            check("event_pc", {1'b0, cpu_pc}, {1'b0, e.pc});
            if (is_mem && e.kind == EV_MEM) begin
              check("mem_address", {3'd0, mem_if.mem_address}, {3'd0, e.addr});
              check("mem_we", {63'd0, mem_if.mem_we}, {63'd0, e.we});
              check("mem_funct3", {61'd0, mem_if.mem_funct3}, {61'd0, e.f3});
              check("mem_wdata", mem_if.mem_wdata, e.wdata);
            end
            if (!is_mem && e.kind == EV_COMMIT) begin
              check("cpu_inst", cpu_inst, e.inst);
              check("load_value", cpu_ram_load_value, e.ldval);
            end
            if (e.dly >= 0) check("event_spacing", 64'(cycle - last_cycle), 64'(e.dly));
          end
          last_cycle = cycle;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_mem();
    cur_test = "reset";
    @(negedge clock); #3;
    @(negedge clock); #3;
    check_reset_outputs();

    // Aligned then misaligned (pc=0x1004) instruction.
    cur_test = "aligned_then_0x1004";
    set_cpu(1'b0, 1'b0, 1'b0, 3'b000, 61'd0, 64'd0, 63'h802);
    push_fetch(61'h200, 63'h800, -1);
    push_commit(63'h800, M200, 64'd0, 1);
    if (!CACHE_EN) push_fetch(61'h200, 63'h802, 1);
    push_fetch(61'h201, 63'h802, CACHE_EN ? -1 : 1);
    push_commit(63'h802, 64'h6666_5555_4444_3333, 64'd0, 1);
    release_reset();
    drain(60);
    enter_reset();

    // pc=0x1006: window straddles two doublewords.
    cur_test = "misaligned_0x1006";
    init_mem();
    set_cpu(1'b0, 1'b0, 1'b0, 3'b000, 61'd0, 64'd0, 63'h803);
    push_fetch(61'h200, 63'h800, -1);
    push_commit(63'h800, M200, 64'd0, 1);
    if (!CACHE_EN) push_fetch(61'h200, 63'h803, 1);
    push_fetch(61'h201, 63'h803, CACHE_EN ? -1 : 1);
    push_commit(63'h803, 64'h7777_6666_5555_4444, 64'd0, 1);
    release_reset();
    drain(60);
    enter_reset();

    // Load with a 3-cycle ack delay.
    cur_test = "load_wait3";
    init_mem();
    ack_delay = 3;
    set_cpu(1'b0, 1'b1, 1'b0, 3'b010, 61'h300, 64'hFFFF_0000_FFFF_0000, 63'h804);
    push_fetch(61'h200, 63'h800, -1);
    push_mem(61'h300, 1'b0, 3'b010, 64'd0, 63'h800, 5);
    push_commit(63'h800, M200, M300, 1);
    release_reset();
    drain(80);
    enter_reset();
    ack_delay = 0;

    // Load and store together act as a store.
    cur_test = "store_over_load";
    init_mem();
    set_cpu(1'b0, 1'b1, 1'b1, 3'b011, 61'h301, 64'h0123_4567_89AB_CDEF, 63'h804);
    push_fetch(61'h200, 63'h800, -1);
    push_mem(61'h301, 1'b1, 3'b011, 64'h0123_4567_89AB_CDEF, 63'h800, 2);
    push_commit(63'h800, M200, 64'd0, 1);
    release_reset();
    drain(60);
    enter_reset();

    // Halt beats store; stray acks while halted must be ignored.
    cur_test = "halt";
    init_mem();
    set_cpu(1'b1, 1'b0, 1'b1, 3'b011, 61'h301, 64'h5555_AAAA_5555_AAAA, 63'h804);
    push_fetch(61'h200, 63'h800, -1);
    release_reset();
    drain(60);
    stray_ack = 1'b1;
    @(negedge clock); #3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #3;
      check("halted_sticky", {63'd0, halted}, 64'd1);
      check("halted_no_req", {63'd0, mem_if.mem_req}, 64'd0);
      check("halted_no_commit", {63'd0, commit}, 64'd0);
    end
    stray_ack = 1'b0;
    enter_reset();
    cur_test = "halt_restart";
    set_cpu(1'b0, 1'b0, 1'b0, 3'b000, 61'd0, 64'd0, 63'h804);
    push_fetch(61'h200, 63'h800, -1);
    push_commit(63'h800, M200, 64'd0, 1);
    release_reset();
    drain(60);
    enter_reset();

    // Asynchronous reset during a pending data access.
    cur_test = "reset_mid_data";
    init_mem();
    ack_delay = 6;
    set_cpu(1'b0, 1'b1, 1'b0, 3'b010, 61'h300, 64'd0, 63'h804);
    push_fetch(61'h200, 63'h800, -1);
    release_reset();
    drain(60);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clock); #3;
        seen = mem_if.mem_req && (mem_if.mem_address == 61'h300);
      end
      if (!seen) begin
        checks++;
        $display("FAIL %s/data_request: got no pending request at 0x300 required one", cur_test);
      end
    end
    #1 reset = 1'b0;
    #1 check_reset_outputs();
    @(negedge clock); #3;
    ack_delay = 0;

`ifdef RV_MEM_SEQUENCER_FETCH_CACHE_EN
    // Self-loop at 0x1000 is served from the fetch buffer after the first pass.
    cur_test = "cache_loop";
    init_mem();
    set_cpu(1'b0, 1'b0, 1'b0, 3'b000, 61'd0, 64'd0, 63'h800);
    push_fetch(61'h200, 63'h800, -1);
    push_commit(63'h800, M200, 64'd0, 1);
    push_commit(63'h800, M200, 64'd0, 2);
    push_commit(63'h800, M200, 64'd0, 2);
    release_reset();
    drain(60);
    enter_reset();

    // A store to the buffered doubleword forces a refetch.
    cur_test = "cache_store_invalidate";
    init_mem();
    set_cpu(1'b0, 1'b0, 1'b1, 3'b011, 61'h200, 64'h0000_0000_0000_0013, 63'h800);
    push_fetch(61'h200, 63'h800, -1);
    push_mem(61'h200, 1'b1, 3'b011, 64'h0000_0000_0000_0013, 63'h800, 2);
    push_commit(63'h800, M200, 64'd0, 1);
    push_fetch(61'h200, 63'h800, 1);
    release_reset();
    drain(60);
    enter_reset();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rv_mem_sequencer.md
Name: rv_mem_sequencer

Overview:
- Multi-cycle controller that sequences one rv_cpu instance over a single shared memory port.
- Owns the architectural pc register, fetches the 64-bit instruction window at pc, and serialises instruction fetch and data load/store onto one req/ack memory channel.
- Issues a one-cycle commit strobe that gates the register/CSR update in the CPU.

Parameters:
reset_pc, 64'h0, pc loaded on reset; bit 0 ignored

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_pc  out  63  current pc[63:1] to CPU
cpu_inst  out  64  instruction window starting at pc
cpu_pcnext  in  63  next pc from CPU
cpu_halt  in  1  CPU fault/illegal indication
cpu_ram_load  in  1  CPU requests data load
cpu_ram_store  in  1  CPU requests data store
cpu_ram_funct3  in  3  access size/sign, forwarded
cpu_ram_address  in  61  data doubleword address [63:3]
cpu_ram_store_value  in  64  pre-shifted store data
cpu_ram_load_value  out  64  latched load doubleword
commit  out  1  one-cycle pulse: CPU state updates this cycle
halted  out  1  sticky halt
mem_req  out  1  memory request valid
mem_we  out  1  1=write, 0=read
mem_funct3  out  3  size for writes (3'b011 on fetch)
mem_address  out  61  doubleword address
mem_wdata  out  64  write data
mem_ack  in  1  transfer completes when mem_req && mem_ack
mem_rdata  in  64  read data, valid on ack cycle

Behaviour:
- Reset (async, reset=0):
  - State IDLE; pc=reset_pc[63:1].
  - mem_req=0, mem_we=0, mem_address=0, mem_wdata=0, mem_funct3=0.
  - commit=0, halted=0, cpu_inst=0, cpu_ram_load_value=0.
  - An in-flight transfer is abandoned; mem_req drops immediately.
- States: IDLE, FETCH0, FETCH1, EXEC, DATA, COMMIT, HALTED.
- IDLE: one cycle after reset release, then FETCH0.
- FETCH0:
  - Request read at pc[63:3]. On ack, latch rdata into fetch_lo.
  - If pc[2:1]==0, go to EXEC. Otherwise go to FETCH1.
- FETCH1:
  - Request read at pc[63:3]+1 (wraps modulo 2^61). On ack, latch fetch_hi and go to EXEC.
- cpu_inst = {fetch_hi,fetch_lo} >> (16*pc[2:1]), truncated to 64 bits. It is stable from EXEC entry until the next FETCH0.
- EXEC (exactly one cycle; CPU outputs sampled):
  - cpu_halt=1: go to HALTED, no commit. Halt has priority over load/store.
  - Else cpu_ram_load or cpu_ram_store: capture address, funct3, store value and we, then go to DATA. If both are asserted, treat as a store.
  - Else: commit=1, pc<=cpu_pcnext, go to FETCH0.
- DATA:
  - mem_req=1 with the captured fields, held stable until ack.
  - On ack: for a load, latch mem_rdata into cpu_ram_load_value. Go to COMMIT.
- COMMIT: commit=1, pc<=pc_captured_in_EXEC's cpu_pcnext, go to FETCH0. The pcnext is captured in EXEC because CPU inputs may change.
- HALTED: absorbing; only reset exits. halted=1, mem_req=0.
- Memory handshake:
  - mem_req, once raised, and all mem_* fields remain stable until the ack cycle.
  - Ack while mem_req=0 is ignored.
  - The next request may be raised the cycle after ack.
- Latency (zero-wait memory, ack same cycle as req):
  - Aligned non-memory instruction: 2 cycles.
  - Misaligned: 3 cycles.
  - Load/store: +2 cycles.
- commit is never asserted in two consecutive cycles.

Optional Feature:
RV_MEM_SEQUENCER_FETCH_CACHE_EN
- With the macro: a two-entry doubleword fetch buffer.
  - Each entry holds tag [63:3], data and valid.
  - Filled round-robin on fetch acks.
  - FETCH0/FETCH1 hit: no mem_req is issued; the state advances after one cycle using the buffered data.
  - A completed store whose address matches an entry's tag invalidates that entry.
  - Reset clears all valid bits.
- Without the macro: every fetch state issues a memory read.

Test Plan:
- Reset release with reset_pc=64'h1000, zero-wait memory, NOP at 0x1000 → FETCH0 reads address 0x200, EXEC commits 2 cycles after IDLE, cpu_pc becomes 0x1004>>1.
- pc=0x1006 with memory[0x200]=64'h4444_3333_2222_1111 and memory[0x201]=64'h8888_7777_6666_5555 → two reads 0x200 then 0x201, cpu_inst=64'h7777_6666_5555_4444.
- Load in EXEC with address 0x300 and a 3-cycle ack delay → mem_req held with stable fields for 3 cycles, cpu_ram_load_value=mem_rdata, single commit pulse after ack.
- cpu_halt=1 with cpu_ram_store=1 in EXEC → no write request, halted=1 permanently, mem_req=0; reset=0 then 1 restarts at reset_pc.
- Assert reset=0 mid-DATA with mem_req=1 → mem_req drops in the same cycle (async), all outputs at reset values.
- With RV_MEM_SEQUENCER_FETCH_CACHE_EN: a loop at 0x1000 issues no fetch reads on its second iteration; a store to 0x200 forces a refetch.
